// File: rtl/hovalaag_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hovalaag_pkg                                              |
// | Purpose  : Shared constants, instruction field positions, state and  |
// |            reason encodings for the Hovalaag run sequencer.          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package hovalaag_pkg;

  // Datapath widths of the Hovalaag core
  localparam int DATA_W  = 12;
  localparam int INSTR_W = 32;
  localparam int PC_W    = 8;

  // Instruction fields the sequencer has to look at
  localparam int A_OP_HI    = 27;
  localparam int A_OP_LO    = 26;
  localparam int IN_SEL_BIT = 13;  // 0 = IN1, 1 = IN2 when A_op selects input
  localparam int OUT_EN_BIT = 14;  // instruction produces an output word
  localparam int HALT_CMP_HI = 27; // bits [31:28] are ignored for halt detection

  localparam logic [1:0] A_OP_INPUT = 2'b11;

  // Jump-to-self with long-form immediate; low byte carries the target PC
  localparam logic [INSTR_W-1:0] NOP_BASE = 32'h0000_9000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } seq_state_t;

  typedef enum logic [1:0] {
    REASON_HALT   = 2'b00,
    REASON_BUDGET = 2'b01,
    REASON_STOP   = 2'b10
  } reason_t;

  // Jump-to-self word for a given program counter
  function automatic logic [INSTR_W-1:0] nop_at(input logic [PC_W-1:0] pc);
    return NOP_BASE | {{(INSTR_W-PC_W){1'b0}}, pc};
  endfunction

endpackage
`default_nettype wire

// File: rtl/hovalaag_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hovalaag_sequencer_if                                     |
// | Purpose  : Host-side stream bundle: two input pushes into the        |
// |            sequencer and one output pop from it.                     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface hovalaag_sequencer_if;
  import hovalaag_pkg::*;

  logic [DATA_W-1:0] in1_data;
  logic              in1_valid;
  logic              in1_ready;
  logic [DATA_W-1:0] in2_data;
  logic              in2_valid;
  logic              in2_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sel;
  logic              out_valid;
  logic              out_ready;

  // Host side: pushes inputs, pops outputs
  modport master (
    output in1_data, in1_valid,
    input  in1_ready,
    output in2_data, in2_valid,
    input  in2_ready,
    input  out_data, out_sel, out_valid,
    output out_ready
  );

  // Sequencer side
  modport slave (
    input  in1_data, in1_valid,
    output in1_ready,
    input  in2_data, in2_valid,
    output in2_ready,
    output out_data, out_sel, out_valid,
    input  out_ready
  );

endinterface
`default_nettype wire

// File: rtl/hovalaag_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hovalaag_fifo                                             |
// | Purpose  : Synchronous first-word-fall-through FIFO with occupancy   |
// |            count. Head reads as zero while empty. Push is refused    |
// |            when full, pop is refused when empty.                     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module hovalaag_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] c_ptr_one   = AW'(1);
  localparam logic [AW:0]   c_cnt_one   = (AW+1)'(1);
  localparam logic [AW:0]   c_cnt_full  = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == c_cnt_full);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_do_push = push && !w_full;
  assign w_do_pop  = pop && !empty;
  assign pop_data  = empty ? '0 : r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/hovalaag_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hovalaag_sequencer                                        |
// | Purpose  : Run controller around one Hovalaag core. Buffers the two  |
// |            input streams and the output stream, holds the core in    |
// |            reset while idle, stalls it with a jump-to-self NOP when  |
// |            I/O cannot proceed, and ends runs on halt, budget or stop.|
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module hovalaag_sequencer
  import hovalaag_pkg::*;
#(
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [CNT_W-1:0]    max_instr,
  output logic                busy,
  output logic                done,
  output logic [1:0]          reason,
  output logic [CNT_W-1:0]    instr_count,
  output logic [CNT_W-1:0]    stall_count,
  hovalaag_sequencer_if.slave host,
  input  logic [INSTR_W-1:0]  mem_instr,
  input  logic [PC_W-1:0]     cpu_pc,
  output logic [INSTR_W-1:0]  cpu_instr,
  output logic                cpu_rst,
  output logic [DATA_W-1:0]   cpu_in1,
  output logic [DATA_W-1:0]   cpu_in2,
  input  logic                cpu_in1_adv,
  input  logic                cpu_in2_adv,
  input  logic [DATA_W-1:0]   cpu_out,
  input  logic                cpu_out_valid,
  input  logic                cpu_out_select
);

  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int OUT_AW = $clog2(OUT_DEPTH);

  localparam logic [IN_AW:0]   c_in_full   = (IN_AW+1)'(IN_DEPTH);
  localparam logic [OUT_AW:0]  c_out_depth = (OUT_AW+1)'(OUT_DEPTH);
  localparam logic [OUT_AW:0]  c_out_one   = (OUT_AW+1)'(1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};

  // --------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------
  seq_state_t       r_state;
  seq_state_t       w_state_next;
  reason_t          r_reason;
  reason_t          w_reason_code;
  logic [CNT_W-1:0] r_instr_count;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_budget;
  logic             r_done;

  // --------------------------------------------------------------------
  // FIFO side signals
  // --------------------------------------------------------------------
  logic              w_in1_empty;
  logic              w_in2_empty;
  logic [IN_AW:0]    w_in1_count;
  logic [IN_AW:0]    w_in2_count;
  logic              w_out_empty;
  logic [OUT_AW:0]   w_out_count;
  logic [DATA_W:0]   w_out_head;
  logic              w_out_push;

  // --------------------------------------------------------------------
  // Decode / control
  // --------------------------------------------------------------------
  logic              w_a_from_input;
  logic              w_need_in1;
  logic              w_need_in2;
  logic              w_need_out;
  logic [OUT_AW:0]   w_out_free;
  logic [OUT_AW:0]   w_out_need;
  logic              w_stall;
  logic              w_is_halt;
  logic              w_budget_hit;
  logic [INSTR_W-1:0] w_nop;
  logic              w_issue;
  logic              w_stall_cycle;
  logic              w_end_run;
  logic              w_start_run;

  // Input FIFO 1: host push, core consume
  hovalaag_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (IN_DEPTH)
  ) u_in1_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (host.in1_valid),
    .push_data (host.in1_data),
    .pop       (cpu_in1_adv),
    .pop_data  (cpu_in1),
    .empty     (w_in1_empty),
    .count     (w_in1_count)
  );

  // Input FIFO 2: host push, core consume
  hovalaag_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (IN_DEPTH)
  ) u_in2_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (host.in2_valid),
    .push_data (host.in2_data),
    .pop       (cpu_in2_adv),
    .pop_data  (cpu_in2),
    .empty     (w_in2_empty),
    .count     (w_in2_count)
  );

  // Output FIFO entries carry the select bit above the data word
  hovalaag_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_out_push),
    .push_data ({cpu_out_select, cpu_out}),
    .pop       (host.out_ready),
    .pop_data  (w_out_head),
    .empty     (w_out_empty),
    .count     (w_out_count)
  );

  assign host.in1_ready = (w_in1_count != c_in_full);
  assign host.in2_ready = (w_in2_count != c_in_full);
  assign host.out_data  = w_out_head[DATA_W-1:0];
  assign host.out_sel   = w_out_head[DATA_W];
  assign host.out_valid = !w_out_empty;

  // Trailing core output is still captured in FLUSH; IDLE output is noise
  // from a core held in reset.
  assign w_out_push = cpu_out_valid && (r_state != ST_IDLE);

  // I/O requirements of the instruction at the current PC
  assign w_a_from_input = (mem_instr[A_OP_HI:A_OP_LO] == A_OP_INPUT);
  assign w_need_in1     = w_a_from_input && !mem_instr[IN_SEL_BIT];
  assign w_need_in2     = w_a_from_input &&  mem_instr[IN_SEL_BIT];
  assign w_need_out     = mem_instr[OUT_EN_BIT];

  // An OUT instruction needs room for its own word plus any word the core
  // is emitting right now. A simultaneous host pop is not credited.
  assign w_out_free = c_out_depth - w_out_count;
  assign w_out_need = c_out_one + (OUT_AW+1)'(cpu_out_valid);

  assign w_stall = (w_need_in1 && w_in1_empty) ||
                   (w_need_in2 && w_in2_empty) ||
                   (w_need_out && (w_out_free < w_out_need));

  assign w_nop        = nop_at(cpu_pc);
  assign w_is_halt    = (mem_instr[HALT_CMP_HI:0] == w_nop[HALT_CMP_HI:0]);
  assign w_budget_hit = (r_budget != '0) && (r_instr_count == r_budget);
  assign w_start_run  = (r_state == ST_IDLE) && start;

  // Next-state and per-cycle issue decisions
  always_comb begin
    w_state_next  = r_state;
    w_reason_code = REASON_HALT;
    w_issue       = 1'b0;
    w_stall_cycle = 1'b0;
    w_end_run     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (stop) begin
          w_state_next  = ST_FLUSH;
          w_reason_code = REASON_STOP;
          w_end_run     = 1'b1;
        end else if (w_budget_hit) begin
          w_state_next  = ST_FLUSH;
          w_reason_code = REASON_BUDGET;
          w_end_run     = 1'b1;
        end else if (w_stall) begin
          w_stall_cycle = 1'b1;
        end else begin
          w_issue = 1'b1;
          if (w_is_halt) begin
            w_state_next  = ST_FLUSH;
            w_reason_code = REASON_HALT;
            w_end_run     = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Run counters, budget latch, end reason and completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_count <= '0;
      r_stall_count <= '0;
      r_budget      <= '0;
      r_reason      <= REASON_HALT;
      r_done        <= 1'b0;
    end else begin
      r_done <= (r_state == ST_FLUSH);
      if (w_start_run) begin
        r_instr_count <= '0;
        r_stall_count <= '0;
        r_budget      <= max_instr;
        r_reason      <= REASON_HALT;
      end
      if (w_issue) r_instr_count <= r_instr_count + c_cnt_one;
      if (w_stall_cycle && (r_stall_count != c_cnt_max))
        r_stall_count <= r_stall_count + c_cnt_one;
      if (w_end_run) r_reason <= w_reason_code;
    end
  end

  assign cpu_instr   = w_issue ? mem_instr : w_nop;
  assign cpu_rst     = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign reason      = r_reason;
  assign instr_count = r_instr_count;
  assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: doc/hovalaag_sequencer.md
# hovalaag_sequencer

Run controller wrapped around one Hovalaag CPU core. It buffers the core's two input streams and one output stream in FIFOs and holds the core in reset while idle. When an instruction cannot complete because its input FIFO is empty or the output FIFO is full, the sequencer stalls the core by substituting a jump-to-self NOP. It also detects program end, enforces an instruction budget, and reports run status.

## Interface
- `IN_DEPTH`, 16: entries per input FIFO, power of two, ≥2
- `OUT_DEPTH`, 16: entries in output FIFO, power of two, ≥2
- `CNT_W`, 16: width of instruction counter and budget
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high; clears FSM, FIFOs, counters
- `start`  in  1  IDLE→RUN request (ignored outside IDLE)
- `stop`  in  1  abort request (effective in RUN only)
- `max_instr`  in  CNT_W  executed-instruction budget, 0 = unlimited; sampled on start
- `busy`  out  1  high in RUN and FLUSH
- `done`  out  1  one-cycle pulse on FLUSH→IDLE
- `reason`  out  2  00 halt, 01 budget, 10 stop; held until next start
- `instr_count`  out  CNT_W  instructions executed in current/last run
- `stall_count`  out  CNT_W  stalled cycles in current/last run, saturating
- `inN_data` in 12, `inN_valid` in 1, `inN_ready` out 1  (N=1,2): host push into input FIFO N
- `out_data` out 12, `out_sel` out 1, `out_valid` out 1, `out_ready` in 1: output FIFO pop; out_sel 0=OUT1, 1=OUT2
- `mem_instr`  in  32  program word at `cpu_pc` (combinational ROM/RAM read)
- `cpu_pc`  in  8  core PC
- `cpu_instr`  out  32  word to core instruction input
- `cpu_rst`  out  1  core synchronous reset
- `cpu_in1`, `cpu_in2`  out  12  FIFO heads (0 when empty)
- `cpu_in1_adv`, `cpu_in2_adv`  in  1  core consume strobes
- `cpu_out` in 12, `cpu_out_valid` in 1, `cpu_out_select` in 1: core output

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE: `cpu_rst`=1, `cpu_instr`=NOP(pc). `start` → RUN, clear counters and `reason`, latch budget.
- RUN: `cpu_rst`=0. Per cycle decode `mem_instr`:
  - need_in1 = [27:26]==11 && [13]==0; need_in2 = [27:26]==11 && [13]==1.
  - need_out = [14].
  - stall if (need_in1 && FIFO1 empty) || (need_in2 && FIFO2 empty) || (need_out && out_free < 1 + cpu_out_valid).
  - Not stalled: `cpu_instr`=`mem_instr`, instr_count++. Stalled: `cpu_instr`=NOP(pc), stall_count++.
- NOP(pc) = 32'h0000_9000 | pc: PC_op=01, long-form immediate, L=pc. All register ops 0; IO bits 0.
- Input pop on `cpu_inN_adv`. Adv cannot occur on a stalled cycle, because the NOP has A_op=00.
- Output push whenever `cpu_out_valid` && state≠IDLE. Entry = {cpu_out_select, cpu_out}.
- Halt: unstalled `mem_instr` equal to NOP(cpu_pc) with [31:28] ignored. That instruction executes, then → FLUSH, reason 00.
- Budget: max_instr≠0 and instr_count reaches max_instr → FLUSH, reason 01; no further instructions issued.
- `stop` in RUN → FLUSH, reason 10 (priority: stop > budget > halt on same cycle). Current cycle still issues NOP.
- FLUSH (one cycle): `cpu_instr`=NOP, captures trailing output, then → IDLE, `done`=1.
- FIFOs persist across runs. Host may preload inputs in IDLE and drain outputs anytime.
- FIFO push/pop same cycle when full/empty:
  - Input full: `inN_ready`=0; push and pop on the same cycle is allowed only when not full.
  - Output: conservative reservation ignores simultaneous pop.

## Timing
- Reset values: busy 0, done 0, reason 00, counts 0, cpu_rst 1, inN_ready 1, out_valid 0, out_data 0, out_sel 0.
- `start` at edge k → RUN at k; `cpu_rst` low from k; first instruction (PC 0) executes at edge k+1.
- Stall decision and `cpu_instr` mux are combinational from `mem_instr`/FIFO state; core sees the result the same cycle.
- Core output appears one cycle after its instruction. It is pushed at the following edge; `out_valid` rises one edge later (registered FIFO).
- Input FIFO: push at edge k visible on `cpu_inN` after k (first-word fall-through).
- Async `rst` mid-run: immediate IDLE, FIFOs emptied, `cpu_rst`=1.
- Counters wrap: instr_count wraps modulo 2^CNT_W; stall_count saturates.

## Structure
- Package `hovalaag_pkg`: instruction field bit positions, state enum, `NOP_BASE`=32'h0000_9000, reason codes.
- Sub-module `hovalaag_fifo` (parameterised width/depth, FWFT, count output), instantiated three times (12,12,13 bits).

## Test plan
- Preload IN1={5,7}, program `A=IN1; W=A; OUT1` ×2 then halt → out {0:5},{0:7}, reason 00, instr_count 5.
- Program reads IN2 with FIFO empty; push 12'hABC after 10 cycles → stall_count 10, cpu_in2_adv once, value reaches output.
- OUT_DEPTH=2, out_ready=0, program emits 4 outputs → core stalls with exactly 2 entries queued; release out_ready → all 4 in order, none lost.
- Infinite loop, max_instr=100 → done after 100 issued instructions, reason 01.
- `stop` and budget expiry on same cycle → reason 10. Async `rst` mid-run → busy 0, FIFOs empty, cpu_rst 1 immediately.
